// File: rtl/vTPU_pkg.sv
// Shared constants and enumerations for the vTPU register-file write path.
package vTPU_pkg;

  localparam int NUM_REGS  = 8;
  localparam int REG_BYTES = 16;

  typedef enum logic [1:0] {
    WM_FULL  = 2'd0,
    WM_LOWER = 2'd1,
    WM_UPPER = 2'd2,
    WM_RSVD  = 2'd3
  } write_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_DONE    = 2'd3
  } asm_state_e;

endpackage

// File: rtl/reg_row_write_assembler_packer.sv
// Lane buffer for one register row: places each accepted byte at offset+count
// and derives the burst length and byte mask from the write mode.
module reg_byte_packer #(
  parameter int REG_BYTES = 16,
  parameter int DATA_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [1:0]                    mode,
  input  logic [DATA_W-1:0]             data,
  output logic [$clog2(REG_BYTES):0]    count_next,
  output logic [$clog2(REG_BYTES):0]    burst_len,
  output logic [REG_BYTES-1:0]          lane_mask,
  output logic [REG_BYTES*DATA_W-1:0]   row_next
);
  import vTPU_pkg::*;

  localparam int CW   = $clog2(REG_BYTES) + 1;
  localparam int HALF = REG_BYTES / 2;
  localparam int RW   = REG_BYTES * DATA_W;

  write_mode_e    mode_s;
  logic [CW-1:0]  count_r;
  logic [CW-1:0]  offset_s;
  logic [CW-1:0]  lane_idx_s;
  logic [CW-1:0]  lane_end_s;
  logic [RW-1:0]  row_r;

  assign mode_s = write_mode_e'(mode);

  // Lane window (start offset and length) selected by the write mode.
  always_comb begin
    offset_s  = {CW{1'b0}};
    burst_len = CW'(REG_BYTES);
    case (mode_s)
      WM_FULL: begin
        offset_s  = {CW{1'b0}};
        burst_len = CW'(REG_BYTES);
      end
      WM_LOWER: begin
        offset_s  = {CW{1'b0}};
        burst_len = CW'(HALF);
      end
      WM_UPPER: begin
        offset_s  = CW'(HALF);
        burst_len = CW'(HALF);
      end
      default: begin
        offset_s  = {CW{1'b0}};
        burst_len = {CW{1'b0}};
      end
    endcase
  end

  assign lane_idx_s = offset_s + count_r;
  assign lane_end_s = offset_s + burst_len;
  assign count_next = wr_en ? (count_r + CW'(1)) : count_r;

  // Byte mask and next row image with the incoming byte merged in.
  always_comb begin
    lane_mask = {REG_BYTES{1'b0}};
    row_next  = row_r;
    for (int i = 0; i < REG_BYTES; i++) begin
      if ((CW'(i) >= offset_s) && (CW'(i) < lane_end_s)) begin
        lane_mask[i] = 1'b1;
      end else begin
        lane_mask[i] = 1'b0;
      end
      if (wr_en && (lane_idx_s == CW'(i))) begin
        row_next[i*DATA_W +: DATA_W] = data;
      end else begin
        row_next[i*DATA_W +: DATA_W] = row_r[i*DATA_W +: DATA_W];
      end
    end
  end

  // Buffer and write-index state; cleared once the row has been handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
      row_r   <= {RW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
      row_r   <= {RW{1'b0}};
    end else begin
      count_r <= count_next;
      row_r   <= row_next;
    end
  end

endmodule

// File: rtl/reg_row_write_assembler.sv
// Packs the controller's byte-serial write stream into one register row and
// commits it to the register-file storage port with a byte mask.
module reg_row_write_assembler #(
  parameter int NUM_REGS  = 8,
  parameter int REG_BYTES = 16,
  parameter int DATA_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_req,
  input  logic [1:0]                    write_mode,
  input  logic [$clog2(NUM_REGS)-1:0]   write_address,
  input  logic [DATA_W-1:0]             write_data,
  output logic                          write_busy,
  output logic                          write_done,
  output logic                          protocol_err,
  output logic                          rf_we,
  output logic [$clog2(NUM_REGS)-1:0]   rf_waddr,
  output logic [REG_BYTES*DATA_W-1:0]   rf_wdata,
  output logic [REG_BYTES-1:0]          rf_wmask
);
  import vTPU_pkg::*;

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(REG_BYTES) + 1;
  localparam int RW = REG_BYTES * DATA_W;

  asm_state_e           state_r;
  asm_state_e           state_s;
  write_mode_e          mode_r;
  write_mode_e          req_mode_s;
  write_mode_e          eff_mode_s;
  logic [AW-1:0]        addr_r;
  logic [AW-1:0]        eff_addr_s;
  logic                 accept_s;
  logic                 err_s;
  logic                 last_s;
  logic                 commit_s;
  logic                 clear_s;
  logic [CW-1:0]        count_next_s;
  logic [CW-1:0]        burst_len_s;
  logic [REG_BYTES-1:0] lane_mask_s;
  logic [RW-1:0]        row_next_s;
  logic [RW-1:0]        row_masked_s;

  logic                 write_done_r;
  logic                 protocol_err_r;
  logic                 rf_we_r;
  logic [AW-1:0]        rf_waddr_r;
  logic [RW-1:0]        rf_wdata_r;
  logic [REG_BYTES-1:0] rf_wmask_r;

  assign req_mode_s = write_mode_e'(write_mode);

  // Request decode: which mode/address apply this cycle, and is the byte taken.
  always_comb begin
    eff_mode_s = mode_r;
    eff_addr_s = addr_r;
    accept_s   = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        eff_mode_s = req_mode_s;
        eff_addr_s = write_address;
        if (write_req && (req_mode_s != WM_RSVD)) begin
          accept_s = 1'b1;
          err_s    = 1'b0;
        end else if (write_req) begin
          accept_s = 1'b0;
          err_s    = 1'b1;
        end else begin
          accept_s = 1'b0;
          err_s    = 1'b0;
        end
      end
      ST_COLLECT: begin
        accept_s = write_req;
        // A mid-burst mode/address change is flagged but the byte still lands in the latched row.
        if (write_req && ((write_address != addr_r) || (req_mode_s != mode_r))) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      default: begin
        accept_s = 1'b0;
        err_s    = 1'b0;
      end
    endcase
  end

  reg_byte_packer #(
    .REG_BYTES (REG_BYTES),
    .DATA_W    (DATA_W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_s),
    .wr_en      (accept_s),
    .mode       (eff_mode_s),
    .data       (write_data),
    .count_next (count_next_s),
    .burst_len  (burst_len_s),
    .lane_mask  (lane_mask_s),
    .row_next   (row_next_s)
  );

  assign last_s  = accept_s && (count_next_s == burst_len_s);
  assign clear_s = (state_r == ST_DONE);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = last_s ? ST_COMMIT : ST_COLLECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (last_s) begin
          state_s = ST_COMMIT;
        end else begin
          state_s = ST_COLLECT;
        end
      end
      ST_COMMIT: state_s = ST_DONE;
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  assign commit_s = (state_s == ST_COMMIT);

  // Force lanes outside the write window to zero on the storage bus.
  always_comb begin
    row_masked_s = {RW{1'b0}};
    for (int i = 0; i < REG_BYTES; i++) begin
      if (lane_mask_s[i]) begin
        row_masked_s[i*DATA_W +: DATA_W] = row_next_s[i*DATA_W +: DATA_W];
      end else begin
        row_masked_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  // State, burst context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      mode_r         <= WM_FULL;
      addr_r         <= {AW{1'b0}};
      write_done_r   <= 1'b0;
      protocol_err_r <= 1'b0;
      rf_we_r        <= 1'b0;
      rf_waddr_r     <= {AW{1'b0}};
      rf_wdata_r     <= {RW{1'b0}};
      rf_wmask_r     <= {REG_BYTES{1'b0}};
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && accept_s) begin
        mode_r <= req_mode_s;
        addr_r <= write_address;
      end
      write_done_r   <= (state_s == ST_DONE);
      protocol_err_r <= err_s;
      rf_we_r        <= commit_s;
      rf_waddr_r     <= commit_s ? eff_addr_s   : {AW{1'b0}};
      rf_wdata_r     <= commit_s ? row_masked_s : {RW{1'b0}};
      rf_wmask_r     <= commit_s ? lane_mask_s  : {REG_BYTES{1'b0}};
    end
  end

  assign write_busy   = (state_r != ST_IDLE);
  assign write_done   = write_done_r;
  assign protocol_err = protocol_err_r;
  assign rf_we        = rf_we_r;
  assign rf_waddr     = rf_waddr_r;
  assign rf_wdata     = rf_wdata_r;
  assign rf_wmask     = rf_wmask_r;

endmodule

// File: tb/tb_reg_row_write_assembler.sv
// Self-checking bench: directed and randomized bursts against a row-level reference model.
module tb_reg_row_write_assembler;

  localparam int NR = 8;
  localparam int RB = 16;
  localparam int DW = 8;
  localparam int AW = $clog2(NR);
  localparam int RW = RB * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_req;
  logic [1:0]    write_mode;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          write_busy;
  logic          write_done;
  logic          protocol_err;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [RW-1:0] rf_wdata;
  logic [RB-1:0] rf_wmask;

  int errors = 0;
  int checks = 0;

  reg_row_write_assembler #(.NUM_REGS(NR), .REG_BYTES(RB), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .write_req     (write_req),
    .write_mode    (write_mode),
    .write_address (write_address),
    .write_data    (write_data),
    .write_busy    (write_busy),
    .write_done    (write_done),
    .protocol_err  (protocol_err),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rf_wmask      (rf_wmask)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_req     = 1'b0;
    write_mode    = 2'd0;
    write_address = '0;
    write_data    = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_we"},    RW'(rf_we),        '0);
    check_val({tag, "_waddr"}, RW'(rf_waddr),     '0);
    check_val({tag, "_wdata"}, rf_wdata,          '0);
    check_val({tag, "_wmask"}, RW'(rf_wmask),     '0);
    check_val({tag, "_done"},  RW'(write_done),   '0);
    check_val({tag, "_perr"},  RW'(protocol_err), '0);
    check_val({tag, "_busy"},  RW'(write_busy),   '0);
  endtask

  // stall_pat: 0 = none, 1 = one idle cycle between bytes, 2 = random idles.
  // The held_* arguments drive write_req during the COMMIT and DONE cycles.
  task automatic run_burst(input int addr, input int mode, input logic [7:0] bytes[$],
                           input int stall_pat, input int bad_idx, input int bad_addr,
                           input bit hold, input int h_mode, input int h_addr,
                           input logic [7:0] h_byte, output int busy_cnt);
    int            len;
    int            off;
    int            k;
    bit            do_stall;
    logic [RW-1:0] exp_data;
    logic [RB-1:0] exp_mask;
    len      = (mode == 0) ? RB : RB / 2;
    off      = (mode == 2) ? RB / 2 : 0;
    exp_data = '0;
    exp_mask = '0;
    busy_cnt = 0;
    for (int j = 0; j < len; j++) begin
      exp_data[(off + j) * DW +: DW] = bytes[j];
      exp_mask[off + j] = 1'b1;
    end
    k = 0;
    while (k < len) begin
      do_stall = (k > 0) && ((stall_pat == 1) || ((stall_pat == 2) && ($urandom_range(99) < 30)));
      if (do_stall) begin
        write_req     = 1'b0;
        write_address = AW'($urandom);
        write_data    = DW'($urandom);
        step();
        if (write_busy) busy_cnt++;
        check_val("stall_we", RW'(rf_we), '0);
        check_val("stall_perr", RW'(protocol_err), '0);
      end
      write_req     = 1'b1;
      write_mode    = 2'(mode);
      write_address = (k == bad_idx) ? AW'(bad_addr) : AW'(addr);
      write_data    = bytes[k];
      step();
      if (write_busy) busy_cnt++;
      check_val("perr", RW'(protocol_err), RW'(k == bad_idx));
      k++;
      check_val((k == len) ? "commit_we" : "collect_we", RW'(rf_we), RW'(k == len));
    end
    check_val("rf_waddr", RW'(rf_waddr), RW'(addr));
    check_val("rf_wmask", RW'(rf_wmask), RW'(exp_mask));
    check_val("rf_wdata", rf_wdata, exp_data);
    if (hold) begin
      write_req     = 1'b1;
      write_mode    = 2'(h_mode);
      write_address = AW'(h_addr);
      write_data    = h_byte;
    end else begin
      idle_inputs();
    end
    step();
    if (write_busy) busy_cnt++;
    check_val("done_pulse", RW'(write_done), RW'(1));
    check_val("done_we", RW'(rf_we), '0);
    step();
    if (write_busy) busy_cnt++;
    check_val("after_done", RW'(write_done), '0);
    check_val("after_busy", RW'(write_busy), '0);
    check_val("after_perr", RW'(protocol_err), '0);
  endtask

  initial begin
    logic [7:0] q[$];
    int         busy;
    int         a;
    int         m;
    int         bi;
    int         ba;

    rst = 1'b1;
    idle_inputs();
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Full row to address 3, bytes 0x00..0x0F back to back.
    q = {};
    for (int i = 0; i < RB; i++) q.push_back(8'(i));
    run_burst(3, 0, q, 0, -1, 0, 1'b0, 0, 0, 8'h00, busy);
    check_val("full_busy_cycles", RW'(busy), RW'(17));

    // Upper half to address 5 with a stall between every byte.
    q = {};
    for (int i = 0; i < RB / 2; i++) q.push_back(8'(8'hA0 + i));
    run_burst(5, 2, q, 1, -1, 0, 1'b0, 0, 0, 8'h00, busy);

    // Reserved mode in IDLE: error pulse, byte dropped, still idle.
    write_req = 1'b1; write_mode = 2'd3; write_address = AW'(4); write_data = 8'h77;
    step();
    check_val("rsvd_perr", RW'(protocol_err), RW'(1));
    check_val("rsvd_busy", RW'(write_busy), '0);
    check_val("rsvd_we", RW'(rf_we), '0);
    idle_inputs();
    step();
    check_val("rsvd_perr_clear", RW'(protocol_err), '0);
    check_val("rsvd_busy2", RW'(write_busy), '0);

    // Lower half to address 2 with byte 4 presented at address 6.
    q = {};
    for (int i = 0; i < RB / 2; i++) q.push_back(8'(8'h30 + i));
    run_burst(2, 1, q, 0, 4, 6, 1'b0, 0, 0, 8'h00, busy);

    // Reset after five bytes of a full-row burst.
    for (int i = 0; i < 5; i++) begin
      write_req = 1'b1; write_mode = 2'd0; write_address = AW'(1); write_data = 8'(8'hE0 + i);
      step();
    end
    idle_inputs();
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    step();
    check_val("midrst_idle_we", RW'(rf_we), '0);
    q = {};
    for (int i = 0; i < RB; i++) q.push_back(8'(8'hC0 + i));
    run_burst(6, 0, q, 0, -1, 0, 1'b0, 0, 0, 8'h00, busy);

    // Back-to-back: next burst's first byte is held through COMMIT and DONE.
    q = {};
    for (int i = 0; i < RB / 2; i++) q.push_back(8'(8'h10 + i));
    run_burst(1, 1, q, 0, -1, 0, 1'b1, 2, 7, 8'h5A, busy);
    q = {};
    q.push_back(8'h5A);
    for (int i = 1; i < RB / 2; i++) q.push_back(8'(8'h60 + i));
    run_burst(7, 2, q, 0, -1, 0, 1'b0, 0, 0, 8'h00, busy);

    // Randomized bursts.
    for (int n = 0; n < 10; n++) begin
      a = $urandom_range(NR - 1);
      m = $urandom_range(2);
      q = {};
      for (int i = 0; i < ((m == 0) ? RB : RB / 2); i++) q.push_back(8'($urandom));
      bi = -1;
      ba = 0;
      if ($urandom_range(1) == 1) begin
        bi = $urandom_range(((m == 0) ? RB : RB / 2) - 1, 1);
        ba = (a + 1 + $urandom_range(NR - 2)) % NR;
      end
      run_burst(a, m, q, 2, bi, ba, 1'b0, 0, 0, 8'h00, busy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
